pipeline_run_ctrl: RTL
======================

// Module: pipeline_run_ctrl
// PURPOSE
//  Run/step controller for the MIPS pipeline. Accepts debug commands, drives the global pipeline enable into the IF/ID/EX/MEM/WB stage registers,
//  counts executed cycles, and stops the pipeline when a HALT retires in WB. Sits between the debug unit and the pipeline stages.
// PARAMETERS
//  NB_CNT   32  width of executed-cycle counter
//  NB_STEP  8   width of step-count operand
// PORTS
//  i_clk           in   1        clock, all state updates on posedge
//  i_rst           in   1        synchronous reset, active-high
//  i_cmd_valid     in   1        command present
//  i_cmd           in   2        00 CLEAR, 01 RUN, 10 STEP, 11 STOP
//  i_step_count    in   NB_STEP  number of cycles for STEP, sampled on acceptance
//  i_halt_wb       in   1        HALT instruction in WB this cycle
//  o_cmd_ready     out  1        constant 1 after reset; every valid command is consumed
//  o_pipe_en       out  1        pipeline stage-register enable
//  o_state         out  2        00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//  o_cycle_count   out  NB_CNT   number of cycles with o_pipe_en=1
//  o_done          out  1        1-cycle pulse: step completed or halt retired
//  o_cmd_err       out  1        1-cycle pulse: command illegal in current state
// BEHAVIOUR
//  - Reset: state=IDLE, o_pipe_en=0, o_cycle_count=0, remaining=0, o_done=0, o_cmd_err=0, o_cmd_ready=0 during reset, 1 after.
//  - o_pipe_en = (state==RUN)||(state==STEP), decoded from the state register. It is never combinational from inputs.
//  - Command accepted at edge k -> new state at edge k -> first enabled cycle is k+1.
//  - o_cycle_count increments on every edge where o_pipe_en=1. It saturates at all-ones.
//  - IDLE:
//    - RUN -> RUN.
//    - STEP with N>0 -> STEP, remaining=N.
//    - STEP with N=0 -> stay in IDLE, o_cmd_err.
//    - CLEAR -> o_cycle_count=0.
//    - STOP -> o_cmd_err.
//  - RUN:
//    - i_halt_wb -> HALTED, o_done.
//    - else STOP -> IDLE.
//    - RUN, STEP or CLEAR -> o_cmd_err, no state change.
//  - STEP:
//    - Each enabled edge decrements remaining.
//    - i_halt_wb -> HALTED, o_done.
//    - else STOP -> IDLE, remaining=0, no o_done.
//    - else remaining==1 -> IDLE, o_done.
//    - RUN, STEP or CLEAR -> o_cmd_err.
//    - STEP N gives exactly N cycles of o_pipe_en=1.
//  - HALTED:
//    - o_pipe_en=0.
//    - Only CLEAR is accepted: -> IDLE, o_cycle_count=0.
//    - All other commands -> o_cmd_err.
//  - Priority within one cycle: i_rst > i_halt_wb > command > step expiry.
//  - The cycle in which a halt or STOP is taken is still an enabled cycle and is counted.
//  - i_halt_wb is ignored while o_pipe_en=0.
//  - o_done and o_cmd_err are registered and high in the cycle following the causing edge.
//  - o_done and o_cmd_err can both pulse in the same cycle: halt taken and an illegal command in the same cycle.
//  - Reset mid-RUN/STEP: the next cycle is IDLE with o_pipe_en=0 and counters cleared. No o_done.
// TESTING
//  1. Reset, STEP N=3 -> o_pipe_en high exactly 3 cycles; then state=IDLE, o_done 1 cycle, o_cycle_count=3.
//  2. RUN, i_halt_wb in 10th enabled cycle -> HALTED, o_cycle_count=10, o_done pulse; then RUN -> o_cmd_err; then CLEAR -> IDLE, count=0.
//  3. RUN, STOP accepted in 5th enabled cycle -> IDLE, o_cycle_count=5, o_done stays 0.
//  4. IDLE: STEP N=0 -> o_cmd_err pulse, o_pipe_en stays 0. IDLE: STOP -> o_cmd_err.
//  5. STEP N=4, i_halt_wb and STOP together in 2nd cycle -> HALTED, o_done=1, count=2.
//  6. NB_CNT=4, RUN 20 cycles -> o_cycle_count=15. Then i_rst mid-STEP (remaining=4) -> IDLE, count=0, o_pipe_en=0.

Source files
------------

// File: rtl/pipeline_run_ctrl.sv
// Run/step controller for the pipeline: accepts debug commands, drives the
// global stage-register enable, counts enabled cycles and stops the pipeline
// when a HALT instruction retires in WB.
module pipeline_run_ctrl #(
    parameter int NB_CNT  = 32,
    parameter int NB_STEP = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    input  logic [NB_STEP-1:0] i_step_count,
    input  logic               i_halt_wb,
    output logic               o_cmd_ready,
    output logic               o_pipe_en,
    output logic [1:0]         o_state,
    output logic [NB_CNT-1:0]  o_cycle_count,
    output logic               o_done,
    output logic               o_cmd_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    localparam logic [NB_STEP-1:0] STEP_ZERO = {NB_STEP{1'b0}};
    localparam logic [NB_STEP-1:0] STEP_ONE  = {{(NB_STEP-1){1'b0}}, 1'b1};
    localparam logic [NB_CNT-1:0]  CNT_ZERO  = {NB_CNT{1'b0}};
    localparam logic [NB_CNT-1:0]  CNT_ONE   = {{(NB_CNT-1){1'b0}}, 1'b1};
    localparam logic [NB_CNT-1:0]  CNT_MAX   = {NB_CNT{1'b1}};

    state_t             state_r;
    logic [NB_STEP-1:0] remaining_r;
    logic [NB_CNT-1:0]  cycle_cnt_r;
    logic               pipe_en_r;
    logic               done_r;
    logic               cmd_err_r;
    logic               cmd_ready_r;

    state_t             state_nxt_s;
    logic [NB_STEP-1:0] remaining_nxt_s;
    logic [NB_CNT-1:0]  cycle_cnt_nxt_s;
    logic               clear_cnt_s;
    logic               done_nxt_s;
    logic               cmd_err_nxt_s;
    logic               halt_s;
    logic               stop_cmd_s;
    logic               illegal_busy_cmd_s;

    // Command/halt qualification; halt only matters while the pipeline moves.
    always_comb begin
        halt_s             = i_halt_wb && pipe_en_r;
        stop_cmd_s         = i_cmd_valid && (i_cmd == CMD_STOP);
        illegal_busy_cmd_s = i_cmd_valid && (i_cmd != CMD_STOP);
    end

    // Next-state, step budget and pulse decode for all four run states.
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        clear_cnt_s     = 1'b0;
        done_nxt_s      = 1'b0;
        cmd_err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    case (i_cmd)
                        CMD_RUN: begin
                            state_nxt_s = ST_RUN;
                        end
                        CMD_STEP: begin
                            if (i_step_count != STEP_ZERO) begin
                                state_nxt_s     = ST_STEP;
                                remaining_nxt_s = i_step_count;
                            end else begin
                                cmd_err_nxt_s = 1'b1;
                            end
                        end
                        CMD_CLEAR: begin
                            clear_cnt_s = 1'b1;
                        end
                        CMD_STOP: begin
                            cmd_err_nxt_s = 1'b1;
                        end
                        default: begin
                            cmd_err_nxt_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A STOP overridden by a halt is still a legal command, not an error.
                cmd_err_nxt_s = illegal_busy_cmd_s;
                if (halt_s) begin
                    state_nxt_s = ST_HALTED;
                    done_nxt_s  = 1'b1;
                end else if (stop_cmd_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STEP: begin
                cmd_err_nxt_s   = illegal_busy_cmd_s;
                remaining_nxt_s = remaining_r - STEP_ONE;
                if (halt_s) begin
                    state_nxt_s     = ST_HALTED;
                    remaining_nxt_s = STEP_ZERO;
                    done_nxt_s      = 1'b1;
                end else if (stop_cmd_s) begin
                    state_nxt_s     = ST_IDLE;
                    remaining_nxt_s = STEP_ZERO;
                end else if (remaining_r <= STEP_ONE) begin
                    // Last budgeted cycle: this edge is the Nth enabled one.
                    state_nxt_s     = ST_IDLE;
                    remaining_nxt_s = STEP_ZERO;
                    done_nxt_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            ST_HALTED: begin
                if (i_cmd_valid) begin
                    if (i_cmd == CMD_CLEAR) begin
                        state_nxt_s = ST_IDLE;
                        clear_cnt_s = 1'b1;
                    end else begin
                        cmd_err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                remaining_nxt_s = STEP_ZERO;
            end
        endcase
    end

    // Saturating count of enabled cycles, cleared by an accepted CLEAR.
    always_comb begin
        if (clear_cnt_s) begin
            cycle_cnt_nxt_s = CNT_ZERO;
        end else if (pipe_en_r && (cycle_cnt_r != CNT_MAX)) begin
            cycle_cnt_nxt_s = cycle_cnt_r + CNT_ONE;
        end else begin
            cycle_cnt_nxt_s = cycle_cnt_r;
        end
    end

    // Controller state register with registered enable and status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= STEP_ZERO;
            cycle_cnt_r <= CNT_ZERO;
            pipe_en_r   <= 1'b0;
            done_r      <= 1'b0;
            cmd_err_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
            cycle_cnt_r <= cycle_cnt_nxt_s;
            // Enable mirrors the registered state: high exactly in RUN and STEP.
            pipe_en_r   <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_STEP);
            done_r      <= done_nxt_s;
            cmd_err_r   <= cmd_err_nxt_s;
            cmd_ready_r <= 1'b1;
        end
    end

    assign o_cmd_ready   = cmd_ready_r;
    assign o_pipe_en     = pipe_en_r;
    assign o_state       = state_r;
    assign o_cycle_count = cycle_cnt_r;
    assign o_done        = done_r;
    assign o_cmd_err     = cmd_err_r;

endmodule
